serial_logic_unit: RTL

SERIAL_LOGIC_UNIT -- requirements
Module: serial_logic_unit

---
 rtl/serial_logic_unit_pkg.sv | 21 ++
 rtl/serial_logic_unit_cell.sv | 22 ++
 rtl/serial_logic_unit.sv | 123 ++++++++++++
 3 files changed

// File: rtl/serial_logic_unit_pkg.sv
// Shared encodings for the logic units: operation select codes and the
// sequencing FSM states.
package serial_logic_unit_pkg;

  localparam logic [1:0] OP_AND  = 2'b00;
  localparam logic [1:0] OP_OR   = 2'b01;
  localparam logic [1:0] OP_XOR  = 2'b10;
  localparam logic [1:0] OP_NAND = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_SHIFT = 2'b01,
    ST_DONE  = 2'b10
  } state_e;

  // Bit counter must hold the value WIDTH itself without wrapping.
  function automatic int cnt_width(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/serial_logic_unit_cell.sv
// One-bit combinational evaluator for the serial logic unit.
module bit_logic_cell
  import serial_logic_unit_pkg::*;
(
  input  logic       a,
  input  logic       b,
  input  logic [1:0] op,
  output logic       r
);

  always_comb begin
    r = 1'b0;
    case (op)
      OP_AND:  r = a & b;
      OP_OR:   r = a | b;
      OP_XOR:  r = a ^ b;
      OP_NAND: r = ~(a & b);
      default: r = 1'b0;
    endcase
  end

endmodule

// File: rtl/serial_logic_unit.sv
// Bit-serial AND/OR/XOR/NAND unit: latches operands on start, evaluates one
// bit per cycle LSB first, and publishes a registered result with a done pulse.
module serial_logic_unit
  import serial_logic_unit_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic [1:0]       op,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             zero
);

  localparam int CNT_W = cnt_width(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] x_q, x_d;
  logic [WIDTH-1:0] y_q, y_d;
  logic [1:0]       op_q, op_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             zero_q, zero_d;
  logic             done_q, done_d;
  logic             bit_r;

  bit_logic_cell u_cell (
    .a  (x_q[0]),
    .b  (y_q[0]),
    .op (op_q),
    .r  (bit_r)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x_q      <= '0;
      y_q      <= '0;
      op_q     <= OP_AND;
      cnt_q    <= '0;
      acc_q    <= '0;
      result_q <= '0;
      zero_q   <= 1'b1;
      done_q   <= 1'b0;
    end else begin
      x_q      <= x_d;
      y_q      <= y_d;
      op_q     <= op_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      result_q <= result_d;
      zero_q   <= zero_d;
      done_q   <= done_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    x_d      = x_q;
    y_d      = y_q;
    op_d     = op_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    result_d = result_q;
    zero_d   = zero_q;
    done_d   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          x_d     = x;
          y_d     = y;
          op_d    = op;
          cnt_d   = '0;
          acc_d   = '0;
          state_d = ST_SHIFT;
        end
      end

      ST_SHIFT: begin
        // New bits enter at the MSB so the first (LSB) bit ends up at bit 0.
        acc_d = {bit_r, acc_q[WIDTH-1:1]};
        x_d   = x_q >> 1;
        y_d   = y_q >> 1;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_LAST) begin
          state_d = ST_DONE;
        end
      end

      ST_DONE: begin
        result_d = acc_q;
        zero_d   = (acc_q == '0);
        done_d   = 1'b1;
        state_d  = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign busy   = (state_q != ST_IDLE);
  assign done   = done_q;
  assign result = result_q;
  assign zero   = zero_q;

endmodule
